// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard / stall / flush controller for a five-stage in-order pipeline.
// Every cycle, one rule is chosen in fixed priority order:
//   reset > global not-ready > MEM busy > EX jump > load-use > fetch drop
//   > fetch busy.
// The chosen rule drives the stall/clear/redirect outputs. Two cycle counters
// also run: stalled cycles (wrapping) and accepted redirects (saturating).
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global ready; low freezes the whole pipeline
//   id_r1_addr/id_r2_addr   ID-stage source register numbers
//   id_r1_used/id_r2_used   source actually read by the ID instruction
//   ex_is_load, ex_rd_addr  EX holds a load, and its destination register
//   ex_jump                 EX resolved a taken branch/jump
//   if_busy, if_done        fetch in flight / fetch return pulse
//   mem_busy                MEM-stage access not yet complete
//   cnt_clr                 clear both performance counters
//   stall_*                 hold the named stage register
//   clear_*                 load a NOP into the named stage register
//   pc_sel_jump             PC loads the EX jump target
//   if_discard              drop the fetch returning this cycle
//   cnt_stall, cnt_flush    performance counters
// ---------------------------------------------------------------------------
module pipeline_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [4:0]  id_r1_addr,
  input  logic [4:0]  id_r2_addr,
  input  logic        id_r1_used,
  input  logic        id_r2_used,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_jump,
  input  logic        if_busy,
  input  logic        if_done,
  input  logic        mem_busy,
  input  logic        cnt_clr,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        stall_mem_wb,
  output logic        clear_if_id,
  output logic        clear_id_ex,
  output logic        clear_mem_wb,
  output logic        pc_sel_jump,
  output logic        if_discard,
  output logic [31:0] cnt_stall,
  output logic [15:0] cnt_flush
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [15:0] FLUSH_MAX = 16'hFFFF;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;      // a fetch made stale by a redirect is still outstanding
  logic [31:0] cnt_stall_q, cnt_stall_d;
  logic [15:0] cnt_flush_q, cnt_flush_d;

  logic        load_use;
  logic        jump_accept;

  // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_is_load && (ex_rd_addr != 5'd0) &&
                    ((id_r1_used && (id_r1_addr == ex_rd_addr)) ||
                     (id_r2_used && (id_r2_addr == ex_rd_addr)));

  // NOTE: every signal written here gets a default first, so no path through
  // the priority chain can leave a value unassigned and infer a latch.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    clear_if_id  = 1'b0;
    clear_id_ex  = 1'b0;
    clear_mem_wb = 1'b0;
    pc_sel_jump  = 1'b0;
    if_discard   = 1'b0;
    jump_accept  = 1'b0;
    state_d      = state_q;
    drop_d       = drop_q;
    cnt_stall_d  = cnt_stall_q;
    cnt_flush_d  = cnt_flush_q;

    if (rst_in) begin
      // Flush every stage register to NOP while reset is held.
      clear_if_id  = 1'b1;
      clear_id_ex  = 1'b1;
      clear_mem_wb = 1'b1;
    end else if (!rdy_in) begin
      // Global freeze: all stages hold, and all registered state holds too.
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      stall_mem_wb = 1'b1;
    end else begin
      // A stale fetch returning is dropped whatever else the pipeline is doing.
      if_discard = drop_q && if_done;
      state_d    = mem_busy ? MEM_WAIT : RUN;

      if (mem_busy) begin
        // MEM is blocked: everything upstream holds, and a bubble goes into WB.
        // A jump in EX stays there and is taken once MEM frees up.
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        clear_mem_wb = 1'b1;
      end else if (ex_jump) begin
        jump_accept = 1'b1;
        pc_sel_jump = 1'b1;
        clear_if_id = 1'b1;
        clear_id_ex = 1'b1;
      end else if (load_use) begin
        // The NOP loaded into ID/EX removes the load from EX next cycle,
        // so the bubble lasts a single cycle.
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        clear_id_ex = 1'b1;
      end else if (drop_q && !if_done) begin
        stall_pc    = 1'b1;
        clear_if_id = 1'b1;
      end else if (if_busy && !drop_q) begin
        stall_pc    = 1'b1;
        clear_if_id = 1'b1;
      end

      // A fetch still in flight when a redirect is taken fetches the wrong
      // path. It is marked for dropping, unless it returns this very cycle:
      // clearing IF/ID already kills that returning fetch.
      if (if_discard) begin
        drop_d = 1'b0;
      end
      if (jump_accept && if_busy && !if_done) begin
        drop_d = 1'b1;
      end

      if (cnt_clr) begin
        cnt_stall_d = '0;
        cnt_flush_d = '0;
      end else begin
        if (stall_pc) begin
          cnt_stall_d = cnt_stall_q + 32'd1;
        end
        if (jump_accept && (cnt_flush_q != FLUSH_MAX)) begin
          cnt_flush_d = cnt_flush_q + 16'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples the pre-edge value of every other flop regardless of ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= RUN;
      drop_q      <= 1'b0;
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      cnt_stall_q <= cnt_stall_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign cnt_stall = cnt_stall_q;
  assign cnt_flush = cnt_flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl. It runs in three parts:
//   1. Single-cycle vector table, applied each time from a clean reset.
//   2. Hand-written multi-cycle sequences for the redirect, stall, freeze,
//      reset and saturation corner cases.
//   3. A long randomized run compared against a rule-level reference model.
// Output vector bit order (MSB..LSB):
//   stall_pc stall_if_id stall_id_ex stall_ex_mem stall_mem_wb
//   clear_if_id clear_id_ex clear_mem_wb pc_sel_jump if_discard
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [4:0]  id_r1_addr, id_r2_addr, ex_rd_addr;
  logic        id_r1_used, id_r2_used, ex_is_load, ex_jump;
  logic        if_busy, if_done, mem_busy, cnt_clr;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic        clear_if_id, clear_id_ex, clear_mem_wb, pc_sel_jump, if_discard;
  logic [31:0] cnt_stall;
  logic [15:0] cnt_flush;

  always #5 clk_in = ~clk_in;

  pipeline_ctrl dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .id_r1_addr  (id_r1_addr),
    .id_r2_addr  (id_r2_addr),
    .id_r1_used  (id_r1_used),
    .id_r2_used  (id_r2_used),
    .ex_is_load  (ex_is_load),
    .ex_rd_addr  (ex_rd_addr),
    .ex_jump     (ex_jump),
    .if_busy     (if_busy),
    .if_done     (if_done),
    .mem_busy    (mem_busy),
    .cnt_clr     (cnt_clr),
    .stall_pc    (stall_pc),
    .stall_if_id (stall_if_id),
    .stall_id_ex (stall_id_ex),
    .stall_ex_mem(stall_ex_mem),
    .stall_mem_wb(stall_mem_wb),
    .clear_if_id (clear_if_id),
    .clear_id_ex (clear_id_ex),
    .clear_mem_wb(clear_mem_wb),
    .pc_sel_jump (pc_sel_jump),
    .if_discard  (if_discard),
    .cnt_stall   (cnt_stall),
    .cnt_flush   (cnt_flush)
  );

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic       ld;
    logic [4:0] rd;
    logic       jmp;
    logic       ibusy;
    logic       idone;
    logic       mbusy;
    logic       clr;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  // Named output patterns.
  localparam logic [9:0] O_NONE   = 10'b00000_00000;
  localparam logic [9:0] O_RESET  = 10'b00000_11100;
  localparam logic [9:0] O_FREEZE = 10'b11111_00000;
  localparam logic [9:0] O_MEM    = 10'b11110_00100;
  localparam logic [9:0] O_JUMP   = 10'b00000_11010;
  localparam logic [9:0] O_LDUSE  = 10'b11000_01000;
  localparam logic [9:0] O_FETCH  = 10'b10000_10000;
  localparam logic [9:0] O_DISC   = 10'b00000_00001;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit          m_wait;
  bit          m_drop;
  logic [31:0] m_cnt_stall;
  int          m_cnt_flush;

  logic [9:0] act;
  assign act = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                clear_if_id, clear_id_ex, clear_mem_wb, pc_sel_jump, if_discard};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic in_t mk(input bit rst, input bit rdy, input logic [4:0] r1, input bit u1,
                             input logic [4:0] r2, input bit u2, input bit ld,
                             input logic [4:0] rd, input bit jmp, input bit ibusy,
                             input bit idone, input bit mbusy, input bit clr);
    in_t x;
    x.rst = rst; x.rdy = rdy; x.r1 = r1; x.u1 = u1; x.r2 = r2; x.u2 = u2;
    x.ld = ld; x.rd = rd; x.jmp = jmp; x.ibusy = ibusy; x.idone = idone;
    x.mbusy = mbusy; x.clr = clr;
    return x;
  endfunction

  function automatic in_t idle();
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Which rule wins: 0 reset, 1 freeze, 2 mem, 3 jump, 4 load-use,
  // 5 stale-fetch wait, 6 fetch busy, 7 none.
  function automatic int rule_of(input in_t x, input bit drop);
    bit hz;
    hz = x.ld && (x.rd != 0) && ((x.u1 && x.r1 == x.rd) || (x.u2 && x.r2 == x.rd));
    if (x.rst)                 return 0;
    if (!x.rdy)                return 1;
    if (x.mbusy)               return 2;
    if (x.jmp)                 return 3;
    if (hz)                    return 4;
    if (drop && !x.idone)      return 5;
    if (x.ibusy && !drop)      return 6;
    return 7;
  endfunction

  function automatic logic [9:0] model_out(input in_t x, input bit drop);
    logic [9:0] o;
    int r;
    r = rule_of(x, drop);
    case (r)
      0:       o = O_RESET;
      1:       o = O_FREEZE;
      2:       o = O_MEM;
      3:       o = O_JUMP;
      4:       o = O_LDUSE;
      5, 6:    o = O_FETCH;
      default: o = O_NONE;
    endcase
    if (r >= 2 && drop && x.idone) o = o | O_DISC;
    return o;
  endfunction

  // Advance the model by one clock edge with inputs x.
  task automatic model_step(input in_t x);
    int  r;
    bit  stalled;
    if (x.rst) begin
      m_wait = 0; m_drop = 0; m_cnt_stall = 0; m_cnt_flush = 0;
    end else if (x.rdy) begin
      r       = rule_of(x, m_drop);
      stalled = (r == 2) || (r == 4) || (r == 5) || (r == 6);
      m_wait  = x.mbusy;
      if (m_drop && x.idone) m_drop = 0;
      if (r == 3 && x.ibusy && !x.idone) m_drop = 1;
      if (x.clr) begin
        m_cnt_stall = 0;
        m_cnt_flush = 0;
      end else begin
        if (stalled) m_cnt_stall = m_cnt_stall + 32'd1;
        if (r == 3 && m_cnt_flush < 65535) m_cnt_flush++;
      end
    end
  endtask

  task automatic drive(input in_t x);
    rst_in = x.rst; rdy_in = x.rdy;
    id_r1_addr = x.r1; id_r1_used = x.u1;
    id_r2_addr = x.r2; id_r2_used = x.u2;
    ex_is_load = x.ld; ex_rd_addr = x.rd; ex_jump = x.jmp;
    if_busy = x.ibusy; if_done = x.idone; mem_busy = x.mbusy; cnt_clr = x.clr;
  endtask

  // Clock without checks, keeping the model in step.
  task automatic run(input in_t x);
    drive(x);
    @(posedge clk_in); #1;
    model_step(x);
  endtask

  // One checked cycle. Inputs change 1 time unit after the edge; outputs are
  // sampled mid-cycle, and counters are sampled just after the next edge.
  task automatic cyc(input string nm, input in_t x, input logic [9:0] exp, input bit use_exp);
    drive(x);
    #4;
    if (use_exp) check({nm, "_out"}, 32'(act), 32'(exp));
    else         check({nm, "_out"}, 32'(act), 32'(model_out(x, m_drop)));
    check({nm, "_state"}, 32'(dut.state_q), 32'(m_wait));
    @(posedge clk_in); #1;
    model_step(x);
    check({nm, "_cstall"}, cnt_stall, m_cnt_stall);
    check({nm, "_cflush"}, 32'(cnt_flush), 32'(m_cnt_flush));
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.rst   = ($urandom_range(99) < 2);
    x.rdy   = ($urandom_range(99) < 88);
    x.r1    = 5'($urandom_range(3));
    x.u1    = 1'($urandom);
    x.r2    = 5'($urandom_range(3));
    x.u2    = 1'($urandom);
    x.ld    = ($urandom_range(99) < 40);
    x.rd    = 5'($urandom_range(3));
    x.jmp   = ($urandom_range(99) < 20);
    x.ibusy = ($urandom_range(99) < 50);
    x.idone = ($urandom_range(99) < 25);
    x.mbusy = ($urandom_range(99) < 20);
    x.clr   = ($urandom_range(99) < 4);
    return x;
  endfunction

  vec_t tbl[14];
  in_t  v;

  initial begin
    // Single-cycle vectors, each applied from a clean reset (no pending drop).
    tbl[0]  = '{"idle",        idle(),                                        O_NONE};
    tbl[1]  = '{"freeze",      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),     O_FREEZE};
    tbl[2]  = '{"mem",         mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),     O_MEM};
    tbl[3]  = '{"mem_jump",    mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0),     O_MEM};
    tbl[4]  = '{"jump",        mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),     O_JUMP};
    tbl[5]  = '{"lduse_r1",    mk(0, 1, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0),     O_LDUSE};
    tbl[6]  = '{"r1_unused",   mk(0, 1, 3, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0),     O_NONE};
    tbl[7]  = '{"lduse_r0",    mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0),     O_NONE};
    tbl[8]  = '{"fetch_busy",  mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),     O_FETCH};
    tbl[9]  = '{"jump_lduse",  mk(0, 1, 0, 0, 5, 1, 1, 5, 1, 0, 0, 0, 0),     O_JUMP};
    tbl[10] = '{"lduse_fetch", mk(0, 1, 0, 0, 5, 1, 1, 5, 0, 1, 0, 0, 0),     O_LDUSE};
    tbl[11] = '{"reset",       mk(1, 0, 5, 1, 5, 1, 1, 5, 1, 1, 1, 1, 1),     O_RESET};
    tbl[12] = '{"freeze_jump", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0),     O_FREEZE};
    tbl[13] = '{"done_nodrop", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),     O_NONE};

    v = idle(); v.rst = 1;
    drive(v);
    @(posedge clk_in); #1;
    model_step(v);

    for (int i = 0; i < 14; i++) begin
      v = idle(); v.rst = 1;
      run(v);
      cyc(tbl[i].name, tbl[i].in, tbl[i].exp, 1'b1);
    end

    // Load-use hazard stalls for one cycle and counts one stalled cycle.
    v = idle(); v.rst = 1;
    cyc("s1_reset", v, O_RESET, 1'b1);
    v = idle(); v.ld = 1; v.rd = 5; v.r2 = 5; v.u2 = 1;
    cyc("s1_hazard", v, O_LDUSE, 1'b1);
    v = idle(); v.rd = 5; v.r2 = 5; v.u2 = 1;
    cyc("s1_after", v, O_NONE, 1'b1);
    check("s1_cnt_stall", cnt_stall, 32'd1);

    // Same hazard shape against register 0: no stall.
    v = idle(); v.ld = 1; v.rd = 0; v.r2 = 0; v.u2 = 1;
    cyc("s2_r0", v, O_NONE, 1'b1);

    // A jump beats the hazard, and the in-flight fetch is dropped three cycles later.
    v = idle(); v.rst = 1;
    run(v);
    v = idle(); v.ld = 1; v.rd = 5; v.r2 = 5; v.u2 = 1; v.jmp = 1; v.ibusy = 1;
    cyc("s3_jump", v, O_JUMP, 1'b1);
    v = idle(); v.ibusy = 1;
    cyc("s3_wait1", v, O_FETCH, 1'b1);
    cyc("s3_wait2", v, O_FETCH, 1'b1);
    v = idle(); v.idone = 1;
    cyc("s3_discard", v, O_DISC, 1'b1);
    cyc("s3_cleared", v, O_NONE, 1'b1);
    check("s3_cnt_flush", 32'(cnt_flush), 32'd1);
    check("s3_cnt_stall", cnt_stall, 32'd2);

    // A jump held behind a busy MEM for four cycles, then taken.
    v = idle(); v.rst = 1;
    run(v);
    for (int i = 0; i < 4; i++) begin
      v = idle(); v.jmp = 1; v.mbusy = 1;
      cyc($sformatf("s4_mem%0d", i), v, O_MEM, 1'b1);
    end
    v = idle(); v.jmp = 1;
    cyc("s4_take", v, O_JUMP, 1'b1);
    check("s4_cnt_flush", 32'(cnt_flush), 32'd1);

    // Freeze during MEM_WAIT: everything holds, including the state.
    v = idle(); v.rst = 1;
    run(v);
    v = idle(); v.mbusy = 1;
    cyc("s5_enter", v, O_MEM, 1'b1);
    for (int i = 0; i < 3; i++) begin
      v = idle(); v.rdy = 0; v.mbusy = 1; v.jmp = 1; v.ibusy = 1;
      cyc($sformatf("s5_freeze%0d", i), v, O_FREEZE, 1'b1);
      check($sformatf("s5_cs%0d", i), cnt_stall, 32'd1);
      check($sformatf("s5_cf%0d", i), 32'(cnt_flush), 32'd0);
    end
    check("s5_state", 32'(dut.state_q), 32'd1);
    v = idle();
    cyc("s5_release", v, O_NONE, 1'b1);
    check("s5_state_run", 32'(dut.state_q), 32'd0);

    // Reset taken in MEM_WAIT with a pending drop abandons both.
    v = idle(); v.jmp = 1; v.ibusy = 1;
    cyc("s6_jump", v, O_JUMP, 1'b1);
    v = idle(); v.mbusy = 1; v.ibusy = 1;
    cyc("s6_mem", v, O_MEM, 1'b1);
    v = idle(); v.rst = 1; v.mbusy = 1;
    cyc("s6_reset", v, O_RESET, 1'b1);
    v = idle(); v.idone = 1;
    cyc("s6_after", v, O_NONE, 1'b1);
    check("s6_state", 32'(dut.state_q), 32'd0);

    // Flush counter saturation, then clear beating a same-cycle increment.
    v = idle(); v.rst = 1;
    run(v);
    v = idle(); v.jmp = 1;
    for (int i = 0; i < 65535; i++) run(v);
    check("s7_sat", 32'(cnt_flush), 32'hFFFF);
    cyc("s7_over", v, O_JUMP, 1'b1);
    check("s7_hold", 32'(cnt_flush), 32'hFFFF);
    v.clr = 1;
    cyc("s7_clr", v, O_JUMP, 1'b1);
    check("s7_clr_flush", 32'(cnt_flush), 32'd0);
    check("s7_clr_stall", cnt_stall, 32'd0);

    // Randomized run against the reference model.
    v = idle(); v.rst = 1;
    run(v);
    for (int i = 0; i < 3000; i++) begin
      cyc($sformatf("rnd%0d", i), rand_in(), O_NONE, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
